// File: rtl/hus_mix_pkg.sv
// Shared definitions for the HUS channel mixer: descriptor field layout,
// accumulator/saturation widths, FSM encoding and the per-channel product helper.
package hus_mix_pkg;

  localparam int VOL_L_LSB    = 0;
  localparam int VOL_R_LSB    = 8;
  localparam int VOL_W        = 8;
  localparam int SMP_LSB      = 0;
  localparam int SMP_W        = 8;
  localparam int EN_BIT       = 15;
  localparam int WORDS_PER_CH = 2;
  localparam int SAT_W        = 16;
  localparam int ACC_W        = 24;
  localparam int PROD_W       = 17;

  localparam logic signed [SAT_W-1:0] SAT_MAX = 16'sh7FFF;
  localparam logic signed [SAT_W-1:0] SAT_MIN = 16'sh8000;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RDV    = 3'd1,
    ST_RDS    = 3'd2,
    ST_MAC    = 3'd3,
    ST_PUSH_L = 3'd4,
    ST_PUSH_R = 3'd5
  } hus_state_e;

  // Signed sample times unsigned volume, sign-extended to accumulator width.
  function automatic logic signed [ACC_W-1:0] mul_vol(input logic [SMP_W-1:0] smp,
                                                      input logic [VOL_W-1:0] vol);
    logic signed [PROD_W-1:0] p;
    p = $signed({{(PROD_W-SMP_W){smp[SMP_W-1]}}, smp}) *
        $signed({{(PROD_W-VOL_W){1'b0}}, vol});
    return {{(ACC_W-PROD_W){p[PROD_W-1]}}, p};
  endfunction

endpackage

// File: rtl/hus_mix_sat.sv
// Combinational clamp of a 24-bit signed accumulator into the 16-bit signed range.
module hus_mix_sat
  import hus_mix_pkg::*;
(
  input  logic signed [ACC_W-1:0] i_acc,
  output logic signed [SAT_W-1:0] o_sat
);

  localparam int HB = ACC_W - SAT_W + 1;

  logic w_fits;

  // The value fits when every bit above the result sign bit copies it.
  assign w_fits = (i_acc[ACC_W-1:SAT_W-1] == {HB{1'b0}}) ||
                  (i_acc[ACC_W-1:SAT_W-1] == {HB{1'b1}});

  // Pass through, or clamp toward the sign of the accumulator.
  always_comb begin
    o_sat = SAT_MAX;
    if (w_fits) begin
      o_sat = i_acc[SAT_W-1:0];
    end else if (i_acc[ACC_W-1]) begin
      o_sat = SAT_MIN;
    end else begin
      o_sat = SAT_MAX;
    end
  end

endmodule

// File: rtl/hus_mix.sv
// Per-sample channel mixer: walks the descriptor RAM, accumulates enabled
// channels' volume-scaled samples, and pushes a saturated L/R word pair.
module hus_mix
  import hus_mix_pkg::*;
#(
  parameter int CHANNELS = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  output logic [7:0]  desc_addr,
  input  logic [15:0] desc_data,
  output logic [15:0] fifo_in,
  output logic        fifo_we,
  input  logic        fifo_full,
  output logic        busy,
  output logic        overrun
);

  localparam logic [6:0] LAST_CH = 7'(CHANNELS - 1);

  hus_state_e              r_state, w_state_nxt;
  logic [6:0]              r_ch, w_ch_nxt;
  logic signed [ACC_W-1:0] r_acc_l, r_acc_r, w_acc_l_nxt, w_acc_r_nxt;
  logic signed [ACC_W-1:0] w_acc_l_mac, w_acc_r_mac, w_sat_in_l;
  logic [VOL_W-1:0]        r_vol_l, r_vol_r, w_vol_l_nxt, w_vol_r_nxt;
  logic [7:0]              r_desc_addr, w_desc_addr_nxt, w_base_cur, w_base_nxt;
  logic [SAT_W-1:0]        r_fifo_in, w_fifo_in_nxt;
  logic signed [SAT_W-1:0] w_sat_l, w_sat_r;
  logic                    r_fifo_we, w_fifo_we_nxt, r_busy, w_busy_nxt;
  logic                    r_overrun, w_overrun_nxt, w_en;
  logic [SMP_W-1:0]        w_smp;
  logic                    w_unused_bits;

  assign w_smp         = desc_data[SMP_LSB +: SMP_W];
  assign w_en          = desc_data[EN_BIT];
  assign w_unused_bits = ^desc_data[14:8];
  assign w_base_cur    = {1'b0, r_ch} * 8'(WORDS_PER_CH);
  assign w_base_nxt    = {1'b0, r_ch + 7'd1} * 8'(WORDS_PER_CH);

  assign w_acc_l_mac = w_en ? (r_acc_l + mul_vol(w_smp, r_vol_l)) : r_acc_l;
  assign w_acc_r_mac = w_en ? (r_acc_r + mul_vol(w_smp, r_vol_r)) : r_acc_r;
  // The left word is launched from the last MAC cycle, so clamp the fresh sum there.
  assign w_sat_in_l  = (r_state == ST_MAC) ? w_acc_l_mac : r_acc_l;

  hus_mix_sat u_sat_l (.i_acc(w_sat_in_l), .o_sat(w_sat_l));
  hus_mix_sat u_sat_r (.i_acc(r_acc_r),    .o_sat(w_sat_r));

  // Next-state and next-output decode.
  always_comb begin
    w_state_nxt     = r_state;
    w_ch_nxt        = r_ch;
    w_acc_l_nxt     = r_acc_l;
    w_acc_r_nxt     = r_acc_r;
    w_vol_l_nxt     = r_vol_l;
    w_vol_r_nxt     = r_vol_r;
    w_desc_addr_nxt = r_desc_addr;
    w_fifo_in_nxt   = r_fifo_in;
    w_fifo_we_nxt   = 1'b0;
    // busy stays high through the right write, so IDLE alone does not mean free.
    w_overrun_nxt   = start & ((r_state != ST_IDLE) | r_busy);
    case (r_state)
      ST_IDLE: begin
        if (start && !r_busy) begin
          w_state_nxt     = ST_RDV;
          w_ch_nxt        = 7'd0;
          w_acc_l_nxt     = '0;
          w_acc_r_nxt     = '0;
          w_desc_addr_nxt = 8'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RDV: begin
        w_desc_addr_nxt = w_base_cur + 8'd1;
        w_state_nxt     = ST_RDS;
      end
      ST_RDS: begin
        w_vol_l_nxt = desc_data[VOL_L_LSB +: VOL_W];
        w_vol_r_nxt = desc_data[VOL_R_LSB +: VOL_W];
        w_state_nxt = ST_MAC;
      end
      ST_MAC: begin
        w_acc_l_nxt = w_acc_l_mac;
        w_acc_r_nxt = w_acc_r_mac;
        if (r_ch == LAST_CH) begin
          if (!fifo_full) begin
            w_fifo_we_nxt = 1'b1;
            w_fifo_in_nxt = w_sat_l;
            w_state_nxt   = ST_PUSH_R;
          end else begin
            w_state_nxt = ST_PUSH_L;
          end
        end else begin
          w_ch_nxt        = r_ch + 7'd1;
          w_desc_addr_nxt = w_base_nxt;
          w_state_nxt     = ST_RDV;
        end
      end
      ST_PUSH_L: begin
        if (!fifo_full) begin
          w_fifo_we_nxt = 1'b1;
          w_fifo_in_nxt = w_sat_l;
          w_state_nxt   = ST_PUSH_R;
        end else begin
          w_state_nxt = ST_PUSH_L;
        end
      end
      ST_PUSH_R: begin
        if (!fifo_full) begin
          w_fifo_we_nxt = 1'b1;
          w_fifo_in_nxt = w_sat_r;
          w_state_nxt   = ST_IDLE;
        end else begin
          w_state_nxt = ST_PUSH_R;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
    w_busy_nxt = (w_state_nxt != ST_IDLE) | w_fifo_we_nxt;
  end

  // State and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_ch        <= 7'd0;
      r_acc_l     <= '0;
      r_acc_r     <= '0;
      r_vol_l     <= '0;
      r_vol_r     <= '0;
      r_desc_addr <= 8'd0;
      r_fifo_in   <= '0;
      r_fifo_we   <= 1'b0;
      r_busy      <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_ch        <= w_ch_nxt;
      r_acc_l     <= w_acc_l_nxt;
      r_acc_r     <= w_acc_r_nxt;
      r_vol_l     <= w_vol_l_nxt;
      r_vol_r     <= w_vol_r_nxt;
      r_desc_addr <= w_desc_addr_nxt;
      r_fifo_in   <= w_fifo_in_nxt;
      r_fifo_we   <= w_fifo_we_nxt;
      r_busy      <= w_busy_nxt;
      r_overrun   <= w_overrun_nxt;
    end
  end

  assign desc_addr = r_desc_addr;
  assign fifo_in   = r_fifo_in;
  assign fifo_we   = r_fifo_we;
  assign busy      = r_busy;
  assign overrun   = r_overrun;

endmodule

// File: tb/tb_hus_mix.sv
// Scoreboard bench for hus_mix: three instances (1, 2 and 16 channels) with
// descriptor RAM models; expected FIFO words are queued and popped by a monitor.
module tb_hus_mix;

  logic        clk = 1'b0;
  logic        rst   [3];
  logic        start [3];
  logic        full  [3];
  logic [7:0]  addr  [3];
  logic [15:0] fin   [3];
  logic        we    [3];
  logic        busy  [3];
  logic        ovr   [3];
  logic [15:0] mem   [3][256];

  logic [17:0] exp_q [$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    logic [15:0] ddata;
    always @(posedge clk) ddata <= mem[g][addr[g]];
    hus_mix #(.CHANNELS((g == 0) ? 1 : (g == 1) ? 2 : 16)) u_dut (
      .clk(clk), .reset(rst[g]), .start(start[g]),
      .desc_addr(addr[g]), .desc_data(ddata),
      .fifo_in(fin[g]), .fifo_we(we[g]), .fifo_full(full[g]),
      .busy(busy[g]), .overrun(ovr[g])
    );
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every FIFO write pops one expected {dut id, word} entry.
  initial begin
    logic [17:0] e;
    forever begin
      @(negedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (we[g] === 1'b1) begin
          chk("we_while_full", {31'd0, full[g]}, 32'd0);
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL fifo_unexpected: dut %0d wrote %04h with nothing expected at %0t", g, fin[g], $time);
          end else begin
            e = exp_q.pop_front();
            chk("fifo_data", {14'd0, 2'(g), fin[g]}, {14'd0, e});
          end
        end
      end
    end
  end

  // One frame: start at cycle 0, optional stall at the left-write decision, optional extra start.
  task automatic run_frame(input int id, input int nch, input int stall, input int ovr_at);
    int last;
    int lw;
    last = 3 * nch + 2 + stall;
    lw   = 3 * nch + 1 + stall;
    @(negedge clk);
    chk("busy_idle", {31'd0, busy[id]}, 32'd0);
    start[id] = 1'b1;
    for (int rel = 1; rel <= last; rel++) begin
      @(negedge clk);
      chk("busy", {31'd0, busy[id]}, 32'd1);
      chk("fifo_we_cycle", {31'd0, we[id]}, {31'd0, (rel == lw) || (rel == lw + 1)});
      chk("overrun", {31'd0, ovr[id]}, {31'd0, (ovr_at > 0) && (rel == ovr_at + 1)});
      if (rel == 1) chk("desc_addr_c1", {24'd0, addr[id]}, 32'd0);
      if (rel == 2) chk("desc_addr_c2", {24'd0, addr[id]}, 32'd1);
      full[id]  = (stall > 0) && (rel >= 3 * nch) && (rel < 3 * nch + stall);
      start[id] = (ovr_at > 0) && (rel == ovr_at);
    end
  endtask

  task automatic set_mixed();
    for (int c = 0; c < 16; c++) begin
      mem[2][2*c]   = 16'h0503;
      mem[2][2*c+1] = 16'h8002;
    end
    mem[2][15] = 16'h0032;
    mem[2][30] = 16'h010A;
    mem[2][31] = 16'h809C;
  endtask

  initial begin
    for (int g = 0; g < 3; g++) begin
      rst[g] = 1'b1; start[g] = 1'b0; full[g] = 1'b0;
      for (int a = 0; a < 256; a++) mem[g][a] = 16'h0000;
    end
    mem[0][0] = 16'h4080; mem[0][1] = 16'h8064;
    mem[1][0] = 16'hFFFF; mem[1][1] = 16'h007F;
    mem[1][2] = 16'h0201; mem[1][3] = 16'h80FF;
    for (int c = 0; c < 16; c++) begin
      mem[2][2*c]   = 16'hFFFF;
      mem[2][2*c+1] = 16'h807F;
    end
    repeat (2) @(negedge clk);
    for (int g = 0; g < 3; g++) begin
      chk("rst_busy", {31'd0, busy[g]}, 32'd0);
      chk("rst_we", {31'd0, we[g]}, 32'd0);
      chk("rst_fifo_in", {16'd0, fin[g]}, 32'd0);
      chk("rst_addr", {24'd0, addr[g]}, 32'd0);
      chk("rst_overrun", {31'd0, ovr[g]}, 32'd0);
      rst[g] = 1'b0;
    end

    exp_q.push_back({2'd0, 16'h3200}); exp_q.push_back({2'd0, 16'h1900});
    run_frame(0, 1, 0, 0);
    exp_q.push_back({2'd1, 16'hFFFF}); exp_q.push_back({2'd1, 16'hFFFE});
    run_frame(1, 2, 0, 0);

    exp_q.push_back({2'd2, 16'h7FFF}); exp_q.push_back({2'd2, 16'h7FFF});
    run_frame(2, 16, 0, 0);
    for (int c = 0; c < 16; c++) mem[2][2*c+1] = 16'h8080;
    exp_q.push_back({2'd2, 16'h8000}); exp_q.push_back({2'd2, 16'h8000});
    run_frame(2, 16, 0, 0);

    set_mixed();
    exp_q.push_back({2'd2, 16'hFC6C}); exp_q.push_back({2'd2, 16'h0028});
    run_frame(2, 16, 0, 5);
    exp_q.push_back({2'd2, 16'hFC6C}); exp_q.push_back({2'd2, 16'h0028});
    run_frame(2, 16, 10, 0);

    // Reset in the middle of a frame: no FIFO write may follow.
    @(negedge clk);
    start[2] = 1'b1;
    for (int rel = 1; rel <= 20; rel++) begin
      @(negedge clk);
      start[2] = 1'b0;
    end
    chk("midframe_busy", {31'd0, busy[2]}, 32'd1);
    rst[2] = 1'b1;
    #1;
    chk("midrst_busy", {31'd0, busy[2]}, 32'd0);
    chk("midrst_addr", {24'd0, addr[2]}, 32'd0);
    chk("midrst_fifo_in", {16'd0, fin[2]}, 32'd0);
    chk("midrst_we", {31'd0, we[2]}, 32'd0);
    repeat (3) @(negedge clk);
    rst[2] = 1'b0;
    repeat (60) @(negedge clk);
    chk("post_rst_busy", {31'd0, busy[2]}, 32'd0);

    exp_q.push_back({2'd2, 16'hFC6C}); exp_q.push_back({2'd2, 16'h0028});
    run_frame(2, 16, 0, 0);

    repeat (5) @(negedge clk);
    chk("queue_drained", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hus_mix.md
# hus_mix

Per-sample channel mixer for the HUS sound engine. Triggered by the sample-rate strobe from the sync stage, it walks the channel descriptor RAM and multiplies each enabled channel's current sample by its left/right volumes. It then pushes one saturated 16-bit left word and one right word into the output FIFO that feeds the DACs. It is the stage directly upstream of the FIFO.

## Interface
Parameters:
- CHANNELS, 16, number of channels mixed per frame, 1..128.

Ports:
- clk  in  1  system clock; the single clock domain.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle sample strobe; begins a mix frame.
- desc_addr  out  8  descriptor RAM read address (word address).
- desc_data  in  16  descriptor RAM read data; valid one clock after desc_addr.
- fifo_in  out  16  signed sample word to the FIFO.
- fifo_we  out  1  FIFO write strobe, one cycle per word.
- fifo_full  in  1  FIFO full flag; no write while high.
- busy  out  1  high while a frame is in progress.
- overrun  out  1  one-cycle pulse when start arrives while busy.

## Operation
- Descriptor layout: channel c uses words 2c and 2c+1.
  - Word 2c is {vol_r[7:0], vol_l[7:0]}; both volumes are unsigned.
  - Word 2c+1 is {en[15], unused[14:8], smp[7:0]}, where smp is signed two's complement.
- Per-channel product: smp × vol, giving a 17-bit signed value (range -32640..+32385).
  - The product is added to acc_l / acc_r only if en=1.
  - Accumulators are 24-bit signed, so there is no internal overflow at 128 channels.
- Output: each accumulator is saturated to 16-bit signed [-32768, 32767]; no shift is applied.
- FSM states: IDLE, RDV, RDS, MAC, PUSH_L, PUSH_R.
  - IDLE: on start, set desc_addr←0, ch←0, acc_l/acc_r←0, then go to RDV.
  - RDV: set desc_addr←2ch+1, then go to RDS.
  - RDS: latch vol_l/vol_r from desc_data (word 2ch), then go to MAC.
  - MAC: accumulate using desc_data (word 2ch+1).
    - If ch=CHANNELS-1, go to PUSH_L.
    - Otherwise set ch←ch+1, desc_addr←2(ch+1), then go to RDV.
  - PUSH_L: when fifo_full=0, assert fifo_we with sat(acc_l) and go to PUSH_R. Otherwise hold.
  - PUSH_R: same as PUSH_L, using sat(acc_r), then go to IDLE.
- Ordering: left is always written before right, and the pair is never split or dropped. A full FIFO stalls the block; it never discards data.
- Overrun: start in any state other than IDLE produces a one-cycle overrun pulse. That start is ignored and the current frame continues unchanged.
- Reset values: every output is 0, and the state is IDLE. Reset mid-frame abandons the frame with no partial FIFO write.

## Timing
- All outputs are registered.
- With start high at cycle 0:
  - busy and desc_addr=0 from cycle 1.
  - Each channel takes 3 cycles.
  - The left write (fifo_we high) occurs at cycle 3·CHANNELS+1.
  - The right write occurs at cycle 3·CHANNELS+2.
  - busy falls at cycle 3·CHANNELS+3, which is the first cycle a new start is accepted.
- With no stalls, a frame lasts 3·CHANNELS+2 cycles. The worst-case sample period must exceed this; at CHANNELS=16 that is 50 cycles.
- fifo_full is sampled in the same cycle as the write decision. fifo_we is never high while fifo_full is high.
- start arriving in the same cycle busy falls is accepted, not flagged.

## Structure
- Shared hus package holds:
  - the descriptor field positions (VOL_L, VOL_R, EN bit, SMP field);
  - the words-per-channel constant (2);
  - the FSM state encoding;
  - the saturation width constant (16).
- One natural sub-module, hus_mix_sat: a combinational 24-to-16-bit signed saturator, instantiated twice (left and right).

## Test plan
- Single channel (CHANNELS=1): vol_l=0x80, vol_r=0x40, smp=+100, en=1 → FIFO receives 12800 (0x3200), then 6400 (0x1900).
- Disabled channel: two channels, ch0 en=0 with smp=+127, vol=0xFF/0xFF; ch1 en=1, smp=-1, vol=1/2 → left = -1 (0xFFFF), right = -2 (0xFFFE).
- Saturation: 16 channels, all smp=+127, vol=0xFF, en=1 → both words 0x7FFF. Same with smp=-128 → both words 0x8000.
- FIFO stall: hold fifo_full=1 for 10 cycles at PUSH_L → no fifo_we while full; left then right are written on consecutive cycles after release; busy is extended by 10 cycles.
- Overrun: second start at cycle 5 of a 16-channel frame → overrun pulses for exactly 1 cycle; exactly two FIFO writes occur, at cycles 49 and 50.
- Reset mid-frame: assert reset at cycle 20 → outputs go to 0 immediately; no FIFO writes occur; the next start produces a correct frame.
